// File: rtl/rrot_sweep_ctrl.sv
// rrot_sweep_ctrl: front-end for an 8-bit right rotator.
// It accepts a byte over a valid/ready handshake and drives the rotator's data and sel inputs.
// It then registers the rotator's output into a result stage that has its own valid/ready handshake.
// Two modes: a single rotation by in_sel, or a sweep of all rotate amounts 0..2^SELW-1.
// Optional build macro RROT_CHECK_EN adds chk_err, a sticky flag.
// chk_err sets when a captured rotator output differs from an internally computed rotate.
module rrot_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SELW-1:0]  in_sel,
  input  logic             in_single,
  output logic [WIDTH-1:0] rot_data,
  output logic [SELW-1:0]  rot_sel,
  input  logic [WIDTH-1:0] rot_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [SELW-1:0]  res_sel,
  output logic             res_last,
  output logic             busy
`ifdef RROT_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q,     state_d;
  logic [WIDTH-1:0] rot_data_q,  rot_data_d;
  logic [SELW-1:0]  rot_sel_q,   rot_sel_d;
  logic             single_q,    single_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q,  res_data_d;
  logic [SELW-1:0]  res_sel_q,   res_sel_d;
  logic             res_last_q,  res_last_d;

  logic slot_free;
  logic is_last;
  logic capture;

  assign slot_free = !res_valid_q || res_ready;
  assign is_last   = single_q || (rot_sel_q == {SELW{1'b1}});
  assign capture   = (state_q == ST_RUN) && slot_free;

  // Next-state logic for the IDLE/RUN controller, the rotator drive and the result stage.
  // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rot_data_d  = rot_data_q;
    rot_sel_d   = rot_sel_q;
    single_d    = single_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_sel_d   = res_sel_q;
    res_last_d  = res_last_q;

    case (state_q)
      ST_IDLE: begin
        // A held result drains here; a new request may be accepted in the same cycle.
        if (res_valid_q && res_ready) res_valid_d = 1'b0;
        if (in_valid) begin
          state_d    = ST_RUN;
          rot_data_d = in_data;
          rot_sel_d  = in_single ? in_sel : '0;
          single_d   = in_single;
        end
      end
      default: begin
        // Under backpressure nothing moves, so rot_sel stays frozen and no amount is skipped.
        if (capture) begin
          res_valid_d = 1'b1;
          res_data_d  = rot_out;
          res_sel_d   = rot_sel_q;
          res_last_d  = is_last;
          if (is_last) state_d = ST_IDLE;
          else         rot_sel_d = rot_sel_q + SELW'(1);
        end
      end
    endcase
  end

  // State registers. Reset is synchronous and overrides any in-flight sweep or held result.
  // NOTE: sequential state uses non-blocking assignments so that all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rot_data_q  <= '0;
      rot_sel_q   <= '0;
      single_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sel_q   <= '0;
      res_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rot_data_q  <= rot_data_d;
      rot_sel_q   <= rot_sel_d;
      single_q    <= single_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_sel_q   <= res_sel_d;
      res_last_q  <= res_last_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign rot_data  = rot_data_q;
  assign rot_sel   = rot_sel_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_sel   = res_sel_q;
  assign res_last  = res_last_q;

`ifdef RROT_CHECK_EN
  logic [2*WIDTH-1:0] rot_dbl;
  logic [WIDTH-1:0]   rot_exp;
  logic               chk_err_q, chk_err_d;

  // Reference right-rotate: shift the doubled word right, and the low half is the rotated value.
  always_comb begin
    rot_dbl   = {rot_data_q, rot_data_q} >> rot_sel_q;
    rot_exp   = rot_dbl[WIDTH-1:0];
    chk_err_d = chk_err_q || (capture && (rot_out != rot_exp));
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_rrot_sweep_ctrl.sv
// Directed testbench for rrot_sweep_ctrl with a behavioural 8-bit right rotator attached.
// When RROT_CHECK_EN is defined, it also checks the chk_err flag by corrupting the rotator model.
module tb_rrot_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic       in_single;
  logic [7:0] rot_data;
  logic [2:0] rot_sel;
  logic [7:0] rot_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_sel;
  logic       res_last;
  logic       busy;
`ifdef RROT_CHECK_EN
  logic       chk_err;
`endif

  logic corrupt_en = 1'b0;
  int   n_checks   = 0;
  int   n_pass     = 0;

  // Rotator output for each of the eight rotate amounts of 0xA5, hand-computed.
  logic [7:0] sweep_a5 [8] = '{8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B};

  always #5 clk = ~clk;

  rrot_sweep_ctrl #(.WIDTH(8), .SELW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_single(in_single),
    .rot_data(rot_data), .rot_sel(rot_sel), .rot_out(rot_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_sel(res_sel), .res_last(res_last), .busy(busy)
`ifdef RROT_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  // Bit-level model of the rotator: out[i] = in[(i+sel) mod 8].
  // The model can corrupt bit 0 when sel is 4.
  always_comb begin
    for (int i = 0; i < 8; i++) rot_out[i] = rot_data[(i + int'(rot_sel)) % 8];
    if (corrupt_en && rot_sel == 3'd4) rot_out[0] = ~rot_out[0];
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge; sample/drive 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [7:0] d, input logic [2:0] s, input logic single);
    in_valid  = 1'b1;
    in_data   = d;
    in_sel    = s;
    in_single = single;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    // Reset with random inputs
    rst       = 1'b1;
    in_valid  = 1'($urandom);
    in_data   = 8'($urandom);
    in_sel    = 3'($urandom);
    in_single = 1'($urandom);
    res_ready = 1'($urandom);
    step();
    step();
    check("rst in_ready", 16'(in_ready), 16'd1);
    check("rst res_valid", 16'(res_valid), 16'd0);
    check("rst rot_data", 16'(rot_data), 16'h00);
    check("rst rot_sel", 16'(rot_sel), 16'd0);
    check("rst busy", 16'(busy), 16'd0);
    check("rst res_data", 16'(res_data), 16'h00);
    check("rst res_last", 16'(res_last), 16'd0);
`ifdef RROT_CHECK_EN
    check("rst chk_err", 16'(chk_err), 16'd0);
`endif
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_single = 1'b0; res_ready = 1'b1;
    step();

    // Single rotate: 0xA5 by 1
    request(8'hA5, 3'd1, 1'b1);
    check("single rot_data", 16'(rot_data), 16'hA5);
    check("single rot_sel", 16'(rot_sel), 16'd1);
    check("single busy", 16'(busy), 16'd1);
    check("single in_ready low", 16'(in_ready), 16'd0);
    check("single res_valid early", 16'(res_valid), 16'd0);
    step();
    check("single res_valid", 16'(res_valid), 16'd1);
    check("single res_data", 16'(res_data), 16'hD2);
    check("single res_sel", 16'(res_sel), 16'd1);
    check("single res_last", 16'(res_last), 16'd1);
    check("single in_ready back", 16'(in_ready), 16'd1);
    step();
    check("single consumed", 16'(res_valid), 16'd0);

    // Full sweep of 0xA5; in_valid pulsed mid-sweep must be ignored.
    request(8'hA5, 3'd5, 1'b0);
    check("sweep rot_sel start", 16'(rot_sel), 16'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin in_valid = 1'b1; in_data = 8'hFF; in_single = 1'b1; in_sel = 3'd2; end
      step();
      in_valid = 1'b0;
      check($sformatf("sweep%0d res_valid", i), 16'(res_valid), 16'd1);
      check($sformatf("sweep%0d res_data", i), 16'(res_data), 16'(sweep_a5[i]));
      check($sformatf("sweep%0d res_sel", i), 16'(res_sel), 16'(i));
      check($sformatf("sweep%0d res_last", i), 16'(res_last), 16'(i == 7));
      check($sformatf("sweep%0d in_ready", i), 16'(in_ready), 16'(i == 7));
      check($sformatf("sweep%0d rot_data", i), 16'(rot_data), 16'hA5);
    end
    step();
    check("sweep drained", 16'(res_valid), 16'd0);
    check("sweep stays idle", 16'(busy), 16'd0);

    // Backpressure: hold the sel=2 result for three cycles.
    request(8'hA5, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    check("bp pre res_data", 16'(res_data), 16'h69);
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp hold%0d res_data", i), 16'(res_data), 16'h69);
      check($sformatf("bp hold%0d res_sel", i), 16'(res_sel), 16'd2);
      check($sformatf("bp hold%0d rot_sel", i), 16'(rot_sel), 16'd3);
      check($sformatf("bp hold%0d res_valid", i), 16'(res_valid), 16'd1);
    end
    res_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      step();
      check($sformatf("bp resume%0d res_data", i), 16'(res_data), 16'(sweep_a5[i]));
      check($sformatf("bp resume%0d res_sel", i), 16'(res_sel), 16'(i));
      check($sformatf("bp resume%0d res_last", i), 16'(res_last), 16'(i == 7));
    end
    step();
    check("bp drained", 16'(res_valid), 16'd0);

    // Reset after the third result of a sweep
    request(8'hA5, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    check("midrst pre res_sel", 16'(res_sel), 16'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst res_valid", 16'(res_valid), 16'd0);
    check("midrst in_ready", 16'(in_ready), 16'd1);
    check("midrst busy", 16'(busy), 16'd0);
    check("midrst rot_sel", 16'(rot_sel), 16'd0);
    request(8'h01, 3'd7, 1'b1);
    step();
    check("post-rst res_data", 16'(res_data), 16'h02);
    check("post-rst res_sel", 16'(res_sel), 16'd7);
    check("post-rst res_last", 16'(res_last), 16'd1);
    check("post-rst in_ready", 16'(in_ready), 16'd1);

    // Single rotate by 0 is identity; result held while a new request is accepted.
    request(8'h3C, 3'd0, 1'b1);
    res_ready = 1'b0;
    step();
    check("sel0 res_data", 16'(res_data), 16'h3C);
    check("sel0 res_last", 16'(res_last), 16'd1);
    request(8'h81, 3'd4, 1'b1);
    check("held accept busy", 16'(busy), 16'd1);
    step();
    check("held wait res_data", 16'(res_data), 16'h3C);
    check("held wait busy", 16'(busy), 16'd1);
    res_ready = 1'b1;
    step();
    check("held new res_data", 16'(res_data), 16'h18);
    check("held new res_sel", 16'(res_sel), 16'd4);
    check("held new busy", 16'(busy), 16'd0);
    step();
    check("held drained", 16'(res_valid), 16'd0);

`ifdef RROT_CHECK_EN
    check("clean chk_err", 16'(chk_err), 16'd0);
    // Corrupt bit 0 on sel=4 during a sweep of 0xA5.
    corrupt_en = 1'b1;
    request(8'hA5, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("chk sweep%0d chk_err", i), 16'(chk_err), 16'(i >= 4));
    end
    step();
    check("chk sticky idle", 16'(chk_err), 16'd1);
    corrupt_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("chk cleared by rst", 16'(chk_err), 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rrot_sweep_ctrl.md
Name: rrot_sweep_ctrl

Overview:
- Sequential front-end that sits directly upstream of the 8-bit right rotator.
- It accepts a data byte over a valid/ready handshake and drives the rotator's data and sel inputs.
- It then captures the rotator's combinational output into a registered result stage with its own valid/ready handshake.
- Two modes: a single rotation by a requested amount, or a sweep of all eight rotate amounts 0..7, in the same order the rotator is characterised.

Parameters:
- WIDTH, 8, data/rotator word width.
- SELW, 3, rotate-amount width; the sweep covers 0..2^SELW-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  byte to rotate.
- in_sel  input  SELW  rotate amount; used only when in_single=1.
- in_single  input  1  1 = one rotation by in_sel; 0 = full sweep 0..7.
- rot_data  output  WIDTH  registered drive to rotator data.
- rot_sel  output  SELW  registered drive to rotator sel.
- rot_out  input  WIDTH  rotator output, combinational from rot_data/rot_sel.
- res_valid  output  1  result register holds a result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  captured rotated value.
- res_sel  output  SELW  rotate amount that produced res_data.
- res_last  output  1  final result of the current request.
- busy  output  1  state is RUN.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE. rot_data=0, rot_sel=0, res_valid=0, res_data=0, res_sel=0, res_last=0, busy=0. Reset is synchronous only, has priority over all other events, and is honoured mid-operation: any in-flight sweep and any held result are discarded.
- States: IDLE, RUN.
- in_ready = (state==IDLE); busy = (state==RUN). Both are combinational from state.
- IDLE behaviour: rot_data and rot_sel hold their last values.
- IDLE -> RUN: taken at an edge where in_valid & in_ready.
  - rot_data <= in_data.
  - rot_sel <= in_single ? in_sel : 0.
  - Internal single flag <= in_single.
- Slot free condition: slot_free = !res_valid | res_ready.
- RUN, on each edge with slot_free:
  - res_data <= rot_out, res_sel <= rot_sel, res_valid <= 1.
  - res_last <= single | (rot_sel == all-ones).
  - If last: go to IDLE; otherwise rot_sel <= rot_sel+1.
- RUN, on each edge without slot_free (backpressure):
  - Everything holds; rot_sel is frozen.
  - No result is lost or duplicated.
- Result consumption: when not in RUN, res_valid clears on an edge with res_valid & res_ready. In RUN, a same-edge consume plus capture keeps res_valid=1 with the new value.
- Latency, handshake at edge k:
  - rot_* are valid after edge k.
  - First result is visible after edge k+1.
  - With res_ready held high, a sweep produces results after edges k+1..k+8; in_ready returns after edge k+8.
  - A single rotation produces its one result after k+1, and the block is back in IDLE after k+1.
- Input handshake: in_valid while in RUN is ignored (in_ready=0). A request accepted while a previous result is still held is legal; its first capture waits for slot_free.
- Rotate-amount width: rot_sel increments are SELW bits. No wrap-around occurs because last terminates the sweep at all-ones. A single rotate with in_sel=0 yields res_data == in_data, res_last=1.
- Output timing: res_* change only at clock edges, never combinationally from res_ready.

Optional Feature:
- Macro: RROT_CHECK_EN.
- Defined:
  - Adds output chk_err (1 bit, reset 0).
  - On every capture edge, rot_out is compared against an internally computed right-rotate of rot_data by rot_sel.
  - On mismatch, chk_err sets at that edge and stays set, clearing only on rst.
- Undefined: the port and the comparison logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst high for 2 cycles with random inputs -> in_ready=1, res_valid=0, rot_data=0x00, rot_sel=0, busy=0.
- Single rotate: in_data=0xA5, in_sel=1, in_single=1, res_ready=1 -> one result res_data=0xD2, res_sel=1, res_last=1 one edge after the handshake; in_ready=1 again on the following cycle.
- Full sweep: in_data=0xA5, in_single=0, res_ready=1 -> eight consecutive results A5, D2, 69, B4, 5A, 2D, 96, 4B with res_sel 0..7; res_last only on sel=7; in_valid pulsed mid-sweep is ignored.
- Backpressure: sweep 0xA5 with res_ready low for 3 cycles while res_sel=2 is held -> res_data stays 0x69, rot_sel stays 3; the sequence resumes with 0xB4 and no value is skipped or repeated.
- Reset mid-sweep: assert rst after the third result -> on the next cycle res_valid=0, in_ready=1, busy=0; a subsequent single rotate of 0x01 by 7 gives 0x02.
- RROT_CHECK_EN: the bench model corrupts rot_out bit 0 on sel=4 during a sweep of 0xA5 -> chk_err rises at that capture edge, stays high through the end of the sweep, and clears only on rst; with the model correct, chk_err stays 0.
